// File: rtl/uart_pkg.sv
// Shared types for the UART TX arbiter.
//   arb_state_t : arbiter FSM state (IDLE = arbitrating, XFER = grant held)
//   UART_BYTE_W : width of one byte lane
package uart_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int UART_BYTE_W = 8;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: finds the first set bit of i_req at or after i_ptr,
// wrapping cyclically.
//   i_req   : request vector
//   i_ptr   : starting index (0..N-1)
//   o_found : any request set
//   o_idx   : chosen index (valid when o_found)
module uart_rr_pick #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_found,
    output logic [IW-1:0] o_idx
);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [IW-1:0]  w_off;
    logic [IW:0]    w_sum;

    // Rotate so that the pointer position lands on bit 0.
    assign w_dbl = {i_req, i_req};
    assign w_rot = w_dbl[i_ptr +: N];

    // Lowest set bit of the rotated vector wins.
    always_comb begin
        w_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IW'(i);
            end
        end
    end

    // Un-rotate: add the pointer back, modulo N.
    assign w_sum   = {1'b0, i_ptr} + {1'b0, w_off};
    assign o_idx   = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : w_sum[IW-1:0];
    assign o_found = |i_req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART TX FIFO write port among N_REQ_p
// valid/ready byte streams. A grant is held until the requester sends a
// byte flagged 'last', MAX_BURST_p bytes have been written, or the FIFO is
// cleared. One arbitration cycle (IDLE) precedes every grant.
//
// Handshake: a byte moves when i_req_valid[k] and o_req_ready[k] are both
// high in the same cycle; ready is only ever raised for the granted index.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_req_valid     : per-requester byte valid
//   i_req_data      : per-requester byte, requester k on [8k+7:8k]
//   i_req_last      : per-requester end-of-packet, qualified by valid
//   o_req_ready     : per-requester ready (one-hot or zero)
//   i_fifo_full     : TX FIFO full, stalls the transfer
//   i_fifo_clear    : TX FIFO clear, aborts the current grant
//   o_fifo_wr_en    : TX FIFO write enable
//   o_fifo_wr_data  : TX FIFO write data (granted byte while XFER, else 0)
//   o_grant_id      : current / most recent grant
//   o_busy          : grant held (XFER)
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ_p     = 4,
    parameter int MAX_BURST_p = 16,
    localparam int GW = $clog2(N_REQ_p)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_REQ_p-1:0]             i_req_valid,
    input  logic [UART_BYTE_W*N_REQ_p-1:0] i_req_data,
    input  logic [N_REQ_p-1:0]             i_req_last,
    output logic [N_REQ_p-1:0]             o_req_ready,
    input  logic                           i_fifo_full,
    input  logic                           i_fifo_clear,
    output logic                           o_fifo_wr_en,
    output logic [UART_BYTE_W-1:0]         o_fifo_wr_data,
    output logic [GW-1:0]                  o_grant_id,
    output logic                           o_busy
);

    localparam logic [7:0] MAX_C = 8'(MAX_BURST_p);

    arb_state_t             r_state, w_next_state;
    logic [GW-1:0]          r_grant, w_next_grant;
    logic [GW-1:0]          r_ptr,   w_next_ptr;
    logic [7:0]             r_count, w_next_count;

    logic                   w_found;
    logic [GW-1:0]          w_pick;
    logic                   w_xfer;
    logic                   w_ready_g;
    logic                   w_transfer;
    logic [UART_BYTE_W-1:0] w_data_g;
    logic [7:0]             w_count_inc;
    logic [GW:0]            w_grant_p1;
    logic [GW-1:0]          w_grant_inc;

    uart_rr_pick #(.N(N_REQ_p)) u_pick (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    assign w_xfer      = (r_state == XFER);
    assign w_ready_g   = w_xfer & ~i_fifo_full & ~i_fifo_clear;
    assign w_transfer  = w_ready_g & i_req_valid[r_grant];
    assign w_data_g    = i_req_data[r_grant*UART_BYTE_W +: UART_BYTE_W];
    assign w_count_inc = r_count + 8'd1;
    assign w_grant_p1  = {1'b0, r_grant} + 1'b1;
    assign w_grant_inc = (w_grant_p1 == (GW+1)'(N_REQ_p)) ? '0 : w_grant_p1[GW-1:0];

    always_comb begin
        o_req_ready = '0;
        if (w_ready_g) begin
            o_req_ready[r_grant] = 1'b1;
        end
    end

    assign o_fifo_wr_en   = w_transfer;
    assign o_fifo_wr_data = w_xfer ? w_data_g : '0;
    assign o_grant_id     = r_grant;
    assign o_busy         = w_xfer;

    always_comb begin
        w_next_state = r_state;
        w_next_grant = r_grant;
        w_next_ptr   = r_ptr;
        w_next_count = r_count;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_next_grant = w_pick;
                    w_next_count = '0;
                    w_next_state = XFER;
                end
            end
            XFER: begin
                if (i_fifo_clear) begin
                    // Abort: the FIFO contents are gone, so the requester
                    // must restart its packet under a later grant.
                    w_next_state = IDLE;
                    w_next_count = '0;
                    w_next_ptr   = w_grant_inc;
                end else if (w_transfer) begin
                    w_next_count = w_count_inc;
                    if (i_req_last[r_grant] || (w_count_inc == MAX_C)) begin
                        w_next_state = IDLE;
                        w_next_count = '0;
                        w_next_ptr   = w_grant_inc;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_grant <= w_next_grant;
            r_ptr   <= w_next_ptr;
            r_count <= w_next_count;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int MAX = 16;
  localparam int GW  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]   valid, last, ready;
  logic [8*N-1:0] data;
  logic           full, clear, wr_en, busy;
  logic [7:0]     wr_data;
  logic [GW-1:0]  grant_id;

  uart_tx_arbiter #(.N_REQ_p(N), .MAX_BURST_p(MAX)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_req_valid    (valid),
    .i_req_data     (data),
    .i_req_last     (last),
    .o_req_ready    (ready),
    .i_fifo_full    (full),
    .i_fifo_clear   (clear),
    .o_fifo_wr_en   (wr_en),
    .o_fifo_wr_data (wr_data),
    .o_grant_id     (grant_id),
    .o_busy         (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model (abstract arbiter state) ----------------
  bit m_busy;
  int m_grant, m_ptr, m_cnt;

  // ---------------- scoreboard / logs ----------------
  logic [7:0] exp_q[$];
  int         wr_src[$];
  logic [7:0] wr_byte[$];
  int         gnt_log[$];
  int         gap_log[$];
  bit         prev_busy;
  int         gap;

  logic [N-1:0] obs_ready;
  logic         obs_wr, obs_busy;
  logic [7:0]   obs_data;
  int           obs_grant;

  // ---------------- byte-stream sources ----------------
  int src_len[N];
  int src_pos[N];
  int src_pkt[N];
  bit src_gate;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_grant = 0; m_ptr = 0; m_cnt = 0;
    exp_q.delete(); wr_src.delete(); wr_byte.delete();
    gnt_log.delete(); gap_log.delete();
    prev_busy = 0; gap = 0;
    for (int k = 0; k < N; k++) begin
      src_len[k] = 0; src_pos[k] = 0; src_pkt[k] = 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; valid = '0; data = '0; last = '0; full = 1'b0; clear = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  // One clock: drive inputs, compare against the model, advance the model.
  task automatic apply_and_check(input logic [N-1:0] v, input logic [8*N-1:0] d,
                                 input logic [N-1:0] l, input logic f, input logic c);
    logic [N-1:0] e_ready;
    logic         e_wr;
    logic [7:0]   e_data;
    int           idx;
    bit           found;
    @(negedge clk);
    valid = v; data = d; last = l; full = f; clear = c;
    #1;
    obs_ready = ready; obs_wr = wr_en; obs_data = wr_data;
    obs_grant = int'(grant_id); obs_busy = busy;

    e_ready = '0;
    if (m_busy && !f && !c) e_ready[m_grant] = 1'b1;
    e_wr   = |(e_ready & v);
    e_data = m_busy ? d[8*m_grant +: 8] : 8'h00;
    check("ready", obs_ready, e_ready);
    check("wr_en", obs_wr, e_wr);
    check("wr_data", obs_data, e_data);
    check("grant_id", obs_grant, m_grant);
    check("busy", obs_busy, m_busy);

    if (e_wr) exp_q.push_back(e_data);
    if (obs_wr) begin
      if (exp_q.size() == 0) check("sb_unexpected_write", 1, 0);
      else check("sb_byte", obs_data, exp_q.pop_front());
      wr_src.push_back(obs_grant);
      wr_byte.push_back(obs_data);
    end
    if (obs_busy && !prev_busy) begin
      gnt_log.push_back(obs_grant);
      gap_log.push_back(gap);
    end
    gap = obs_busy ? 0 : gap + 1;
    prev_busy = obs_busy;

    if (!m_busy) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!found && v[idx]) begin found = 1; m_grant = idx; end
      end
      if (found) begin m_busy = 1; m_cnt = 0; end
    end else if (c) begin
      m_busy = 0; m_cnt = 0; m_ptr = (m_grant + 1) % N;
    end else if (e_wr) begin
      m_cnt++;
      if (l[m_grant] || m_cnt == MAX) begin
        m_busy = 0; m_cnt = 0; m_ptr = (m_grant + 1) % N;
      end
    end
  endtask

  // One clock driven from the sources; sources advance on their own handshake.
  task automatic run_cycle(input logic f, input logic c);
    logic [N-1:0]   v, l;
    logic [8*N-1:0] d;
    v = '0; l = '0; d = '0;
    for (int k = 0; k < N; k++) begin
      d[8*k +: 8] = 8'(k * 64 + src_pos[k]);
      if (src_pos[k] < src_len[k] && (!src_gate || $urandom_range(3) != 0)) v[k] = 1'b1;
      l[k] = ((src_pos[k] + 1) % src_pkt[k] == 0);
    end
    apply_and_check(v, d, l, f, c);
    for (int k = 0; k < N; k++)
      if (obs_ready[k] && v[k]) src_pos[k]++;
    if (c && obs_busy) src_pos[obs_grant] = 0;
  endtask

  function automatic bit sources_done();
    for (int k = 0; k < N; k++)
      if (src_pos[k] < src_len[k]) return 0;
    return 1;
  endfunction

  task automatic drain(input string name, input int budget);
    for (int t = 0; t < budget && !(sources_done() && !m_busy); t++) run_cycle(1'b0, 1'b0);
    check({name, "_drained"}, sources_done(), 1);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [N-1:0]   v;
    logic [8*N-1:0] d;
    logic [N-1:0]   l;
    logic           f, c;
    logic [N-1:0]   e_ready;
    logic           e_wr;
    logic [7:0]     e_data;
    logic [GW-1:0]  e_gnt;
    logic           e_busy;
  } vec_t;

  vec_t vt[13];

  initial begin
    // v       d             l       f  c  ready   wr data   gnt busy
    vt[0]  = '{4'b0010, 32'h0000_4100, 4'b0000, 0, 0, 4'b0000, 0, 8'h00, 0, 0};
    vt[1]  = '{4'b0010, 32'h0000_4100, 4'b0000, 0, 0, 4'b0010, 1, 8'h41, 1, 1};
    vt[2]  = '{4'b0010, 32'h0000_4200, 4'b0000, 1, 0, 4'b0000, 0, 8'h42, 1, 1};
    vt[3]  = '{4'b0010, 32'h0000_4200, 4'b0000, 0, 0, 4'b0010, 1, 8'h42, 1, 1};
    vt[4]  = '{4'b0010, 32'h0000_4300, 4'b0010, 0, 0, 4'b0010, 1, 8'h43, 1, 1};
    vt[5]  = '{4'b0000, 32'h0000_0000, 4'b0000, 0, 0, 4'b0000, 0, 8'h00, 1, 0};
    vt[6]  = '{4'b1001, 32'h3300_0011, 4'b0000, 0, 0, 4'b0000, 0, 8'h00, 1, 0};
    vt[7]  = '{4'b1001, 32'h3300_0011, 4'b1000, 0, 0, 4'b1000, 1, 8'h33, 3, 1};
    vt[8]  = '{4'b0000, 32'h0000_0000, 4'b0000, 0, 0, 4'b0000, 0, 8'h00, 3, 0};
    vt[9]  = '{4'b0001, 32'h0000_0011, 4'b0000, 0, 1, 4'b0000, 0, 8'h00, 3, 0};
    vt[10] = '{4'b0001, 32'h0000_0011, 4'b0000, 0, 0, 4'b0001, 1, 8'h11, 0, 1};
    vt[11] = '{4'b0001, 32'h0000_0012, 4'b0000, 0, 1, 4'b0000, 0, 8'h12, 0, 1};
    vt[12] = '{4'b0000, 32'h0000_0000, 4'b0000, 0, 0, 4'b0000, 0, 8'h00, 0, 0};

    rst_n = 1'b0; valid = '0; data = '0; last = '0; full = 1'b0; clear = 1'b0;
    src_gate = 0;
    model_reset();

    // ---- reset state ----
    do_reset();
    #1;
    check("rst_ready", ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_grant", grant_id, 0);
    check("rst_busy", busy, 0);

    // ---- table: single requester, stall, IDLE clear, abort ----
    for (int i = 0; i < 13; i++) begin
      apply_and_check(vt[i].v, vt[i].d, vt[i].l, vt[i].f, vt[i].c);
      check($sformatf("vec%0d_ready", i), obs_ready, vt[i].e_ready);
      check($sformatf("vec%0d_wr", i), obs_wr, vt[i].e_wr);
      check($sformatf("vec%0d_data", i), obs_data, vt[i].e_data);
      check($sformatf("vec%0d_grant", i), obs_grant, vt[i].e_gnt);
      check($sformatf("vec%0d_busy", i), obs_busy, vt[i].e_busy);
    end

    // ---- all four valid, 2-byte packets: order 0,1,2,3,0 ----
    do_reset();
    for (int k = 0; k < N; k++) begin src_len[k] = 2; src_pkt[k] = 2; end
    src_len[0] = 4;
    drain("rr", 100);
    check("rr_grants", gnt_log.size(), 5);
    if (gnt_log.size() == 5) begin
      check("rr_g0", gnt_log[0], 0);
      check("rr_g1", gnt_log[1], 1);
      check("rr_g2", gnt_log[2], 2);
      check("rr_g3", gnt_log[3], 3);
      check("rr_g4", gnt_log[4], 0);
      for (int i = 1; i < 5; i++) check($sformatf("rr_gap%0d", i), gap_log[i], 1);
    end

    // ---- burst limit: req2 20 bytes, req3 waiting ----
    do_reset();
    src_len[2] = 20; src_pkt[2] = 20;
    src_len[3] = 3;  src_pkt[3] = 3;
    drain("burst", 100);
    check("burst_grants", gnt_log.size(), 3);
    if (gnt_log.size() == 3) begin
      check("burst_g0", gnt_log[0], 2);
      check("burst_g1", gnt_log[1], 3);
      check("burst_g2", gnt_log[2], 2);
    end
    check("burst_writes", wr_byte.size(), 23);
    if (wr_byte.size() == 23) begin
      check("burst_16th", wr_byte[15], 8'h8F);
      check("burst_src16", wr_src[16], 3);
      check("burst_resume17", wr_byte[19], 8'h90);
    end

    // ---- FIFO full for 5 clocks mid-packet ----
    do_reset();
    src_len[0] = 6; src_pkt[0] = 6;
    for (int t = 0; t < 20 && wr_byte.size() < 2; t++) run_cycle(1'b0, 1'b0);
    check("full_reached", wr_byte.size(), 2);
    for (int i = 0; i < 5; i++) begin
      run_cycle(1'b1, 1'b0);
      check("full_no_wr", obs_wr, 0);
      check("full_no_ready", obs_ready, 0);
      check("full_busy", obs_busy, 1);
    end
    drain("full", 50);
    check("full_count", wr_byte.size(), 6);
    for (int i = 0; i < 6 && i < wr_byte.size(); i++)
      check($sformatf("full_byte%0d", i), wr_byte[i], 8'(i));

    // ---- FIFO clear during req0 byte 2 of 4 ----
    do_reset();
    src_len[0] = 4; src_pkt[0] = 4;
    src_len[1] = 2; src_pkt[1] = 2;
    for (int t = 0; t < 20 && wr_byte.size() < 1; t++) run_cycle(1'b0, 1'b0);
    check("clr_reached", wr_byte.size(), 1);
    run_cycle(1'b0, 1'b1);
    check("clr_no_wr", obs_wr, 0);
    run_cycle(1'b0, 1'b0);
    check("clr_idle", obs_busy, 0);
    run_cycle(1'b0, 1'b0);
    check("clr_next_busy", obs_busy, 1);
    check("clr_next_grant", obs_grant, 1);
    drain("clr", 50);
    check("clr_writes", wr_byte.size(), 7);
    if (wr_byte.size() == 7) begin
      check("clr_src1", wr_src[1], 1);
      check("clr_src3", wr_src[3], 0);
      check("clr_restart", wr_byte[3], 8'h00);
    end

    // ---- asynchronous reset mid-burst ----
    do_reset();
    src_len[0] = 10; src_pkt[0] = 10;
    src_len[2] = 2;  src_pkt[2] = 2;
    src_len[3] = 2;  src_pkt[3] = 2;
    for (int t = 0; t < 20 && wr_byte.size() < 3; t++) run_cycle(1'b0, 1'b0);
    check("arst_reached", wr_byte.size(), 3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready", ready, 0);
    check("arst_wr_en", wr_en, 0);
    check("arst_wr_data", wr_data, 0);
    check("arst_grant", grant_id, 0);
    check("arst_busy", busy, 0);
    valid = '0; last = '0; data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    m_busy = 0; m_grant = 0; m_ptr = 0; m_cnt = 0;
    exp_q.delete(); gnt_log.delete(); gap_log.delete(); prev_busy = 0;
    src_pos[0] = 0;
    rst_n = 1'b1;
    for (int t = 0; t < 10 && gnt_log.size() < 1; t++) run_cycle(1'b0, 1'b0);
    check("arst_first_grant_seen", gnt_log.size(), 1);
    if (gnt_log.size() >= 1) check("arst_first_grant", gnt_log[0], 0);
    drain("arst", 60);

    // ---- randomized traffic against the model ----
    do_reset();
    src_gate = 1;
    for (int t = 0; t < 1500; t++) begin
      for (int k = 0; k < N; k++) begin
        if (src_pos[k] >= src_len[k] && $urandom_range(9) == 0) begin
          src_len[k] = $urandom_range(40, 1);
          src_pkt[k] = src_len[k];
          src_pos[k] = 0;
        end
      end
      run_cycle(1'($urandom_range(4) == 0), 1'($urandom_range(39) == 0));
    end
    src_gate = 0;
    drain("rand", 400);
    check("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
